// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel millisecond timer.
// Holds channel state/mode encodings and prescaler sizing functions.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN_HI,
    RUN_LO
  } tmr_state_t;

  typedef enum logic {
    ONE_SHOT,
    PERIODIC
  } tmr_mode_t;

  function automatic int calc_div(
    input int clk_hz,
    input int tick_hz
  );
    return clk_hz / tick_hz;
  endfunction

  function automatic int calc_sub_w(
    input int div
  );
    return $clog2(div);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: FSM, per-channel prescaler and tick counter.
// Ports: clk, rst, start, stop, mode, load in; out, busy, done out.
module timer_channel
  import timer_pkg::*;
#(
  parameter int DIV   = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] load,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int SUB_W = calc_sub_w(DIV);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(DIV - 1);

  tmr_state_t       state_q, state_d;
  tmr_mode_t        mode_q, mode_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic             done_q, done_d;
  logic             sub_end;
  logic             phase_end;

  assign sub_end   = (sub_q == SUB_MAX);
  assign phase_end = sub_end &&
                     (tick_q == load_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= ONE_SHOT;
      sub_q   <= '0;
      tick_q  <= '0;
      load_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sub_q   <= sub_d;
      tick_q  <= tick_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sub_d   = sub_q;
    tick_d  = tick_q;
    load_d  = load_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      sub_d   = '0;
      tick_d  = '0;
    end else if (start && (load != '0)) begin
      // retrigger restarts the prescaler too,
      // so the high time carries no phase jitter
      state_d = RUN_HI;
      mode_d  = tmr_mode_t'(mode);
      load_d  = load;
      sub_d   = '0;
      tick_d  = '0;
    end else if (state_q != IDLE) begin
      if (phase_end) begin
        sub_d  = '0;
        tick_d = '0;
        unique case (state_q)
          RUN_HI: begin
            done_d  = 1'b1;
            state_d = (mode_q == PERIODIC) ?
                      RUN_LO : IDLE;
          end
          RUN_LO:  state_d = RUN_HI;
          default: state_d = IDLE;
        endcase
      end else if (sub_end) begin
        sub_d  = '0;
        tick_d = tick_q + CNT_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  assign out  = (state_q == RUN_HI);
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: rtl/multi_channel_timer.sv
// N-channel programmable tick-based timer (one-shot / periodic).
// Ports: CLK1, RST, start/stop/mode/load per channel; out/busy/done.
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 16
) (
  input  logic                       CLK1,
  input  logic                       RST,
  input  logic [N_CH-1:0]            start,
  input  logic [N_CH-1:0]            stop,
  input  logic [N_CH-1:0]            mode,
  input  logic [N_CH-1:0][CNT_W-1:0] load,
  output logic [N_CH-1:0]            out,
  output logic [N_CH-1:0]            busy,
  output logic [N_CH-1:0]            done
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("multi_channel_timer: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(
      .DIV   (DIV),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk   (CLK1),
      .rst   (RST),
      .start (start[i]),
      .stop  (stop[i]),
      .mode  (mode[i]),
      .load  (load[i]),
      .out   (out[i]),
      .busy  (busy[i]),
      .done  (done[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer with a 10-cycle tick.
// Drives and samples 1 time unit after each rising clock edge.
module tb_multi_channel_timer;

  logic             CLK1;
  logic             RST;
  logic [3:0]       start;
  logic [3:0]       stop;
  logic [3:0]       mode;
  logic [3:0][15:0] load;
  logic [3:0]       out;
  logic [3:0]       busy;
  logic [3:0]       done;

  int compared;
  int mismatched;
  int hi, dn, bm, errs, fall, n;
  logic [3:0] eo, ed;

  multi_channel_timer #(
    .N_CH    (4),
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .CNT_W   (16)
  ) dut (
    .CLK1  (CLK1),
    .RST   (RST),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .load  (load),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial CLK1 = 1'b0;
  always #5 CLK1 = ~CLK1;

  task automatic step(input int k);
    repeat (k) begin
      @(posedge CLK1);
      #1;
    end
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    RST   = 1'b1;
    start = '0;
    stop  = '0;
    mode  = '0;
    load  = '0;

    // reset
    step(10);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    RST = 1'b0;
    step(1);

    // ch1 one-shot, load=100 -> 1000 cycles high
    load[1] = 16'd100;
    mode[1] = 1'b0;
    start   = 4'b0010;
    step(1);
    start = '0;
    chk("os_rise", 32'(out), 32'h2);
    chk("os_busy", 32'(busy), 32'h2);
    hi = 1; dn = 0; bm = 0; n = 0;
    while (out[1] && n < 2000) begin
      step(1);
      n++;
      if (out[1]) hi++;
      if (done[1]) dn++;
      if (busy !== out) bm++;
    end
    chk("os_done_at_fall", 32'(done), 32'h2);
    repeat (5) begin
      step(1);
      if (done[1]) dn++;
    end
    chk("os_high_cycles", 32'(hi), 32'd1000);
    chk("os_done_count", 32'(dn), 32'd1);
    chk("os_busy_eq_out", 32'(bm), 32'd0);

    // ch0 periodic, load=3 -> 30 high / 30 low
    load[0] = 16'd3;
    mode[0] = 1'b1;
    start   = 4'b0001;
    errs = 0; dn = 0;
    for (int k = 1; k <= 180; k++) begin
      step(1);
      start = '0;
      eo = (((k - 1) / 30) % 2 == 0) ? 4'b0001 : 4'b0000;
      ed = ((k > 1) && ((k - 1) % 30 == 0) &&
            (((k - 1) / 30) % 2 == 1)) ? 4'b0001 : 4'b0000;
      if (out !== eo || done !== ed) errs++;
      if (busy !== 4'b0001) errs++;
      if (done[0]) dn++;
    end
    chk("per_wave_errs", 32'(errs), 32'd0);
    chk("per_done_count", 32'(dn), 32'd3);
    stop = 4'b0001;
    step(1);
    stop = '0;
    chk("per_stop_busy", 32'(busy), 32'h0);
    chk("per_stop_done", 32'(done), 32'h0);

    // ch2 one-shot load=5, retrigger 20 cycles after first start
    load[2] = 16'd5;
    mode[2] = 1'b0;
    start   = 4'b0100;
    errs = 0; dn = 0;
    for (int k = 1; k <= 80; k++) begin
      step(1);
      start = '0;
      eo = (k < 70) ? 4'b0100 : 4'b0000;
      ed = (k == 70) ? 4'b0100 : 4'b0000;
      if (out !== eo || done !== ed) errs++;
      if (done[2]) dn++;
      if (k == 19) start = 4'b0100;
    end
    chk("retrig_errs", 32'(errs), 32'd0);
    chk("retrig_done_count", 32'(dn), 32'd1);

    // ch3 stop and start together mid-run
    load[3] = 16'd4;
    mode[3] = 1'b0;
    start   = 4'b1000;
    step(1);
    start = '0;
    step(9);
    chk("pre_stop_busy", 32'(busy), 32'h8);
    stop  = 4'b1000;
    start = 4'b1000;
    step(1);
    stop  = '0;
    start = '0;
    chk("stop_out", 32'(out), 32'h0);
    chk("stop_busy", 32'(busy), 32'h0);
    chk("stop_done", 32'(done), 32'h0);
    n = 0;
    repeat (60) begin
      step(1);
      if (done !== 4'b0 || out !== 4'b0) n++;
    end
    chk("stop_quiet", 32'(n), 32'd0);

    // load=0 start while idle is ignored
    load[3] = 16'd0;
    start   = 4'b1000;
    step(1);
    start = '0;
    chk("zero_idle_busy", 32'(busy), 32'h0);

    // load=0 start while running is ignored
    load[3] = 16'd4;
    start   = 4'b1000;
    step(1);
    start = '0;
    step(2);
    load[3] = 16'd0;
    start   = 4'b1000;
    step(1);
    start = '0;
    chk("zero_run_busy", 32'(busy), 32'h8);
    fall = 0;
    for (int k = 5; k <= 60; k++) begin
      step(1);
      if (!out[3] && fall == 0) fall = k;
    end
    chk("zero_run_fall", 32'(fall), 32'd41);

    // ch0 load=2 and ch2 load=4 started together
    load[0] = 16'd2;
    mode[0] = 1'b0;
    load[2] = 16'd4;
    mode[2] = 1'b0;
    start   = 4'b0101;
    errs = 0;
    for (int k = 1; k <= 50; k++) begin
      step(1);
      start = '0;
      eo = {1'b0, (k < 41), 1'b0, (k < 21)};
      ed = {1'b0, (k == 41), 1'b0, (k == 21)};
      if (out !== eo || done !== ed) errs++;
      if (k == 21) chk("conc_done0", 32'(done), 32'h1);
      if (k == 41) chk("conc_done2", 32'(done), 32'h4);
    end
    chk("conc_errs", 32'(errs), 32'd0);

    // reset mid-run
    load[0] = 16'd3;
    mode[0] = 1'b1;
    load[1] = 16'd9;
    mode[1] = 1'b0;
    start   = 4'b0011;
    step(1);
    start = '0;
    step(5);
    chk("pre_rst_busy", 32'(busy), 32'h3);
    RST = 1'b1;
    step(1);
    chk("mid_rst_out", 32'(out), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    RST = 1'b0;
    step(3);
    chk("post_rst_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
